// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   DATA_W_DEFAULT : default sample width (signed fixed point)
//   POOL_K         : pooling window edge / stride
//   MAX_W          : widest sample the signed max helper handles
//   pool_state_e   : max-pool FSM state encoding
//   smax()         : signed maximum of two sign-extended samples
package cnn_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int POOL_K         = 2;
  localparam int MAX_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } pool_state_e;

  // Callers sign-extend narrower samples to MAX_W before calling.
  function automatic logic signed [MAX_W-1:0] smax(input logic signed [MAX_W-1:0] a,
                                                   input logic signed [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and buffer address generation for max_pool_unit.
// Walks channel c, pooled row r, pooled column k and read phase ph.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : zero all counters (controller idle)
//   step         : advance the read phase (one read issued this cycle)
//   advance      : move to the next window (one write issued this cycle)
//   ph           : current read phase 0..3
//   last_phase   : ph is the final read of the window
//   last_window  : current window is the last one of the layer
//   rd_addr      : conv-buffer address for the current phase
//   wr_addr      : pooled-buffer address of the current window
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int CH     = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              advance,
  output logic [1:0]        ph,
  output logic              last_phase,
  output logic              last_window,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int OW = IMG_W / POOL_K;
  localparam int OH = IMG_H / POOL_K;

  localparam logic [ADDR_W-1:0] ONE           = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CH_STRIDE_RD  = ADDR_W'(IMG_W * IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE_RD = ADDR_W'(POOL_K * IMG_W);
  localparam logic [ADDR_W-1:0] COL_STRIDE_RD = ADDR_W'(POOL_K);
  localparam logic [ADDR_W-1:0] CH_STRIDE_WR  = ADDR_W'(OW * OH);
  localparam logic [ADDR_W-1:0] ROW_STRIDE_WR = ADDR_W'(OW);
  localparam logic [ADDR_W-1:0] K_LAST        = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] R_LAST        = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] C_LAST        = ADDR_W'(CH - 1);

  logic [1:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] c_q, c_d, r_q, r_d, k_q, k_d;
  logic [ADDR_W-1:0] rd_off;
  logic              k_last, r_last, c_last;

  assign k_last = (k_q == K_LAST);
  assign r_last = (r_q == R_LAST);
  assign c_last = (c_q == C_LAST);

  always_comb begin
    ph_d = ph_q;
    c_d  = c_q;
    r_d  = r_q;
    k_d  = k_q;
    if (clear) begin
      ph_d = '0;
      c_d  = '0;
      r_d  = '0;
      k_d  = '0;
    end else begin
      if (step) ph_d = ph_q + 2'd1;  // 3 wraps to 0 for the next window
      if (advance) begin
        if (!k_last) begin
          k_d = k_q + ONE;
        end else begin
          k_d = '0;
          if (!r_last) begin
            r_d = r_q + ONE;
          end else begin
            r_d = '0;
            c_d = c_last ? '0 : c_q + ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= '0;
      c_q  <= '0;
      r_q  <= '0;
      k_q  <= '0;
    end else begin
      ph_q <= ph_d;
      c_q  <= c_d;
      r_q  <= r_d;
      k_q  <= k_d;
    end
  end

  // Phase order: top-left, top-right, bottom-left, bottom-right.
  always_comb begin
    case (ph_q)
      2'd0:    rd_off = '0;
      2'd1:    rd_off = ONE;
      2'd2:    rd_off = ADDR_W'(IMG_W);
      default: rd_off = ADDR_W'(IMG_W + 1);
    endcase
  end

  assign rd_addr     = c_q * CH_STRIDE_RD + r_q * ROW_STRIDE_RD + k_q * COL_STRIDE_RD + rd_off;
  assign wr_addr     = c_q * CH_STRIDE_WR + r_q * ROW_STRIDE_WR + k_q;
  assign ph          = ph_q;
  assign last_phase  = (ph_q == 2'd3);
  assign last_window = k_last && r_last && c_last;

endmodule

// File: rtl/max_pool_unit.sv
// 2x2 stride-2 max-pooling engine. Reads the conv output buffer (1-cycle
// read latency) and writes one pooled value per window, all channels per
// start. Five cycles per window: four reads then one write.
// Optional feature: define POOL_RELU_EN to clamp negative results to 0.
//   clk, rst   : clock, synchronous active-high reset
//   start      : level enable from the layer controller
//   rd_en      : conv-buffer read enable
//   rd_addr    : conv-buffer read address (held when rd_en is low)
//   rd_data    : conv-buffer data, valid the cycle after rd_en
//   wr_en      : pooled-buffer write enable
//   wr_addr    : pooled-buffer write address (held when wr_en is low)
//   wr_data    : pooled value (held when wr_en is low)
//   pool_done  : one-cycle pulse after the last window is written
module max_pool_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int CH     = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              pool_done
);

  localparam int OW    = IMG_W / POOL_K;
  localparam int OH    = IMG_H / POOL_K;
  localparam bit EMPTY = (OW == 0) || (OH == 0);

  if (longint'(CH) * longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_w_check
    $error("max_pool_unit: ADDR_W too narrow for CH*IMG_W*IMG_H");
  end
  if (DATA_W > MAX_W || DATA_W < 2) begin : g_data_w_check
    $error("max_pool_unit: DATA_W out of supported range");
  end

  function automatic logic signed [DATA_W-1:0] max_s(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return DATA_W'(smax(MAX_W'(a), MAX_W'(b)));
  endfunction

  pool_state_e              state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] pool_val;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;
  logic [1:0]               ag_ph;
  logic                     ag_last_phase, ag_last_window;
  logic [ADDR_W-1:0]        ag_rd_addr, ag_wr_addr;

  pool_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CH    (CH),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == ST_IDLE),
    .step       (state_q == ST_READ),
    .advance    (state_q == ST_WRITE),
    .ph         (ag_ph),
    .last_phase (ag_last_phase),
    .last_window(ag_last_window),
    .rd_addr    (ag_rd_addr),
    .wr_addr    (ag_wr_addr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; dropping start during READ/WRITE aborts the layer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = EMPTY ? ST_DONE : ST_READ;
      ST_READ:  if (!start) state_d = ST_IDLE;
                else if (ag_last_phase) state_d = ST_WRITE;
      ST_WRITE: if (!start) state_d = ST_IDLE;
                else state_d = ag_last_window ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_HOLD;
      ST_HOLD:  if (!start) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The phase-3 sample is still on rd_data during WRITE, so it is folded in
  // combinationally instead of spending a cycle loading it into acc.
  always_comb begin
    pool_val = max_s(acc_q, $signed(rd_data));
`ifdef POOL_RELU_EN
    if (pool_val[DATA_W-1]) pool_val = '0;
`endif
  end

  // rd_data seen in phase p belongs to the read issued in phase p-1.
  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_READ) begin
      if (ag_ph == 2'd1)      acc_d = $signed(rd_data);
      else if (ag_ph != 2'd0) acc_d = max_s(acc_q, $signed(rd_data));
    end
  end

  // Output logic
  always_comb begin
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    pool_done = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_READ: begin
        rd_en     = 1'b1;
        rd_addr_d = ag_rd_addr;
      end
      ST_WRITE: begin
        wr_en     = 1'b1;
        wr_addr_d = ag_wr_addr;
        wr_data_d = pool_val;
      end
      ST_DONE: pool_done = 1'b1;
      default: ;
    endcase
  end

  assign rd_addr = rd_addr_d;
  assign wr_addr = wr_addr_d;
  assign wr_data = wr_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: doc/max_pool_unit.md
Name: max_pool_unit

Overview:
- 2x2, stride-2 max-pooling engine driven by the layer controller's `pool` strobe; it returns `pool_done` to that controller.
- Reads the convolution output buffer (synchronous RAM, 1-cycle read latency) and writes one pooled value per window to the pooled-feature buffer.
- Processes all channels of one layer per start.

Parameters:
- DATA_W, 16, signed fixed-point sample width.
- IMG_W, 26, conv output map width (columns).
- IMG_H, 26, conv output map height (rows).
- CH, 8, number of channels stored back-to-back in the conv buffer.
- ADDR_W, 13, address width of both buffers; must cover CH*IMG_W*IMG_H.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level enable from layer controller (`pool`); held high while its POOL state is active.
- rd_en  out  1  conv-buffer read enable.
- rd_addr  out  ADDR_W  conv-buffer read address.
- rd_data  in  DATA_W  conv-buffer read data, valid the cycle after rd_en.
- wr_en  out  1  pooled-buffer write enable.
- wr_addr  out  ADDR_W  pooled-buffer write address.
- wr_data  out  DATA_W  pooled value.
- pool_done  out  1  one-cycle pulse when the last window is written.

Behaviour:
- Derived sizes: OW=IMG_W/2 and OH=IMG_H/2, floor division. For an odd dimension, the last column/row is ignored. N=CH*OH*OW windows.
- Reset (on the clk edge with rst=1): state IDLE; all counters 0; rd_en=0, wr_en=0, pool_done=0, rd_addr=0, wr_addr=0, wr_data=0. Reset mid-operation aborts immediately; no partial write completes after the reset edge.
- FSM states: IDLE, READ, WRITE, DONE, HOLD.
  - IDLE: wait for start=1 → READ. Counters c (channel), r (row), k (col), ph (phase 0..3) are cleared.
  - READ: one rd_en per cycle for ph=0..3.
    - base = c*IMG_W*IMG_H + 2r*IMG_W + 2k.
    - Addresses per phase: ph0=base, ph1=base+1, ph2=base+IMG_W, ph3=base+IMG_W+1.
    - After ph3 → WRITE.
  - Running max register `acc`:
    - Loaded with rd_data in the cycle after ph0.
    - Updated as acc=max(acc, rd_data) after ph1 and after ph2.
    - Compare is signed.
  - WRITE: wr_en=1, wr_data=max(acc, rd_data) (the ph3 data, combinationally), wr_addr=c*OH*OW + r*OW + k.
    - Advance k, then wrap into r, then wrap into c.
    - → READ if windows remain, else → DONE.
  - DONE: pool_done=1 for exactly one cycle → HOLD.
  - HOLD: wait for start=0 → IDLE. A still-high start must not retrigger processing.
- Timing: cycle 0 = first clk edge sampling start=1 in IDLE.
  - Reads occupy cycles 1–4; the write is cycle 5; 5 cycles per window.
  - Last write at cycle 5N; pool_done at cycle 5N+1.
- Abort: start=0 while in READ or WRITE → IDLE on the next edge.
  - No pool_done is issued.
  - A write scheduled in that same cycle still occurs.
- rd_en and wr_en are never high in the same cycle.
- rd_addr and wr_addr are held at their last value when their enable is low.
- Address arithmetic is done at ADDR_W width; no wrap is permitted. Parameter legality (ADDR_W sufficient) is checked by elaboration-time assertion.
- Degenerate case OW=0 or OH=0 (IMG_W<2 or IMG_H<2): IDLE → DONE directly; pool_done at cycle 1; no reads or writes.

Optional Feature:
- Macro POOL_RELU_EN.
- Defined: fused ReLU. wr_data = (max < 0) ? 0 : max, applied in the WRITE cycle; latency unchanged.
- Undefined: wr_data is the raw signed max, so negative outputs pass through.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W default.
  - Pool FSM state encoding (3-bit: IDLE=0, READ=1, WRITE=2, DONE=3, HOLD=4).
  - POOL_K=2 constant.
  - Signed max function.
- One natural sub-module, pool_addr_gen:
  - Owns c/r/k/ph counters and the read/write address computation.
  - Exposes `last_phase` and `last_window` flags.
- The top module keeps the FSM, acc and the output registers.

Test Plan:
- IMG_W=IMG_H=4, CH=1, buffer=0..15 → writes {5,7,13,15} at addresses 0..3; pool_done at cycle 21; rd_en high 16 cycles.
- Negative data: window {-3,-9,-1,-7} → wr_data=-1. With POOL_RELU_EN: wr_data=0.
- IMG_W=IMG_H=5, CH=2 → N=8. Channel-1 reads start at address 25; the column-4/row-4 addresses (e.g. 4, 20, 24) are never read; pooled writes go to addresses 0..7.
- start held high after pool_done for 10 cycles → no further rd_en; drop start, re-raise → second full pass with identical writes.
- start dropped at cycle 7 mid-run → no pool_done; IDLE at cycle 8. Reset asserted mid-READ → all outputs 0 on the next edge; restart completes normally.
